// File: rtl/nibble_input_conditioner_if.sv
// Signal bundle between the pushbutton conditioner and its user (processor IN port side).
// Ports: btn_raw/tick/rd_strobe flow into the conditioner; btn_level/btn_rise/btn_data/pending flow out.
// master = driver of raw buttons and read strobe; slave = the conditioner itself.
interface nibble_input_conditioner_if;
  logic [3:0] btn_raw;    // raw asynchronous button levels, 1 = pressed
  logic       tick;       // debounce sample enable
  logic       rd_strobe;  // IN-read acknowledge (oeIN)
  logic [3:0] btn_level;  // debounced level
  logic [3:0] btn_rise;   // one-cycle pulse on debounced press
  logic [3:0] btn_data;   // nibble for the processor pushbuttons input
  logic       pending;    // any bit of btn_data set

  modport master (
    output btn_raw, tick, rd_strobe,
    input  btn_level, btn_rise, btn_data, pending
  );

  modport slave (
    input  btn_raw, tick, rd_strobe,
    output btn_level, btn_rise, btn_data, pending
  );
endinterface

// File: rtl/nibble_input_conditioner.sv
// Four-channel pushbutton conditioner: 2-flop sync, per-channel debounce, press edge detect, optional press latch.
// Latency: raw change before edge E0 shows on btn_level/btn_rise after edge E0+DEBOUNCE_CYCLES+1 (tick tied high).
// No backpressure; with INPUT_STICKY_EN defined presses are held until rd_strobe, otherwise btn_data follows btn_level.
// Ports: clk, reset (async, active-high), bus (nibble_input_conditioner_if.slave).
module nibble_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 15  // legal 1..65535
) (
  input logic                        clk,
  input logic                        reset,
  nibble_input_conditioner_if.slave  bus
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_nxt;
  logic [3:0]       rise_q;
  logic [3:0]       rise_nxt;
  logic [3:0][15:0] count;
  logic [3:0][15:0] count_nxt;

  // Any sample that agrees with the stable value restarts the count, so only
  // DEBOUNCE_CYCLES consecutive disagreeing ticks can flip a channel.
  always_comb begin
    stable_nxt = stable;
    count_nxt  = count;
    for (int i = 0; i < 4; i++) begin
      if (sync2[i] == stable[i]) begin
        count_nxt[i] = '0;
      end else if (bus.tick) begin
        if (count[i] == LAST_COUNT) begin
          stable_nxt[i] = sync2[i];
          count_nxt[i]  = '0;
        end else begin
          count_nxt[i] = count[i] + 16'd1;
        end
      end
    end
    // Registering the transition makes the pulse coincide with the new level.
    rise_nxt = stable_nxt & ~stable;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      count  <= '0;
      rise_q <= '0;
    end else begin
      sync1  <= bus.btn_raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      count  <= count_nxt;
      rise_q <= rise_nxt;
    end
  end

  assign bus.btn_level = stable;
  assign bus.btn_rise  = rise_q;

`ifdef INPUT_STICKY_EN
  logic [3:0] press;

  // Clear first, then OR in new rises: a rise in the read cycle is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press <= '0;
    end else begin
      press <= (press & ~{4{bus.rd_strobe}}) | rise_q;
    end
  end

  assign bus.btn_data = press;
  assign bus.pending  = |press;
`else
  assign bus.btn_data = stable;
  assign bus.pending  = |stable;
`endif

endmodule

// File: tb/tb_nibble_input_conditioner.sv
// Directed testbench for nibble_input_conditioner with DEBOUNCE_CYCLES = 4.
// Honors INPUT_STICKY_EN the same way as the design to pick expected btn_data values.
module tb_nibble_input_conditioner;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  nibble_input_conditioner_if nif ();

  nibble_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (nif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cleanup();
    nif.btn_raw   = 4'b0000;
    nif.rd_strobe = 1'b0;
    nif.tick      = 1'b1;
    reset = 1'b1;
    edge_n(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_level, exp_rise, exp_data;
    nif.btn_raw   = 4'b1111;
    nif.tick      = 1'b1;
    nif.rd_strobe = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      edge_n(1);
      tests_run++;
      if ({nif.btn_level, nif.btn_rise, nif.btn_data, nif.pending} !== 13'd0) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got lvl=%b rise=%b data=%b pend=%b required all 0",
                 c, nif.btn_level, nif.btn_rise, nif.btn_data, nif.pending);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      edge_n(1);
      exp_level = (e >= 5) ? 4'b1111 : 4'b0000;
      exp_rise  = (e == 5) ? 4'b1111 : 4'b0000;
`ifdef INPUT_STICKY_EN
      exp_data  = (e >= 6) ? 4'b1111 : 4'b0000;
`else
      exp_data  = exp_level;
`endif
      tests_run++;
      if (nif.btn_level !== exp_level || nif.btn_rise !== exp_rise) begin
        tests_failed++;
        $display("FAIL reset_release edge %0d: got lvl=%b rise=%b required lvl=%b rise=%b",
                 e, nif.btn_level, nif.btn_rise, exp_level, exp_rise);
      end
      tests_run++;
      if (nif.btn_data !== exp_data || nif.pending !== (|exp_data)) begin
        tests_failed++;
        $display("FAIL reset_release_data edge %0d: got data=%b pend=%b required data=%b pend=%b",
                 e, nif.btn_data, nif.pending, exp_data, |exp_data);
      end
    end
    cleanup();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_level, exp_rise, exp_data;
    nif.btn_raw = 4'b0001;
    for (int e = 0; e < 28; e++) begin
      edge_n(1);
      exp_level = (e >= 5 && e < 25) ? 4'b0001 : 4'b0000;
      exp_rise  = (e == 5) ? 4'b0001 : 4'b0000;
`ifdef INPUT_STICKY_EN
      exp_data  = (e >= 6) ? 4'b0001 : 4'b0000;
`else
      exp_data  = exp_level;
`endif
      tests_run++;
      if (nif.btn_level !== exp_level || nif.btn_rise !== exp_rise) begin
        tests_failed++;
        $display("FAIL clean_press edge %0d: got lvl=%b rise=%b required lvl=%b rise=%b",
                 e, nif.btn_level, nif.btn_rise, exp_level, exp_rise);
      end
      tests_run++;
      if (nif.btn_data !== exp_data || nif.pending !== (|exp_data)) begin
        tests_failed++;
        $display("FAIL clean_press_data edge %0d: got data=%b pend=%b required data=%b pend=%b",
                 e, nif.btn_data, nif.pending, exp_data, |exp_data);
      end
      if (e == 19) nif.btn_raw = 4'b0000;
    end
    cleanup();
  endtask

  task automatic test_glitch();
    logic [3:0] exp_level;
    // Three high samples reach sync2: one short of the debounce threshold.
    nif.btn_raw = 4'b0010;
    for (int e = 0; e < 12; e++) begin
      edge_n(1);
      if (e == 2) nif.btn_raw = 4'b0000;
      tests_run++;
      if (nif.btn_level !== 4'b0000 || nif.btn_rise !== 4'b0000) begin
        tests_failed++;
        $display("FAIL glitch edge %0d: got lvl=%b rise=%b required lvl=0000 rise=0000",
                 e, nif.btn_level, nif.btn_rise);
      end
    end
    cleanup();
    // tick on edges 2,5,8,11: sync2 goes high after edge 1, fourth tick is edge 11.
    nif.tick    = 1'b0;
    nif.btn_raw = 4'b0001;
    for (int e = 0; e < 14; e++) begin
      edge_n(1);
      nif.tick  = (((e + 1) % 3) == 2);
      exp_level = (e >= 11) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (nif.btn_level !== exp_level || nif.btn_rise !== ((e == 11) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL gated_tick edge %0d: got lvl=%b rise=%b required lvl=%b rise=%b",
                 e, nif.btn_level, nif.btn_rise, exp_level, (e == 11) ? 4'b0001 : 4'b0000);
      end
    end
    cleanup();
  endtask

`ifdef INPUT_STICKY_EN
  task automatic test_sticky_read();
    logic [3:0] exp_data;
    nif.btn_raw = 4'b0100;
    for (int e = 0; e < 40; e++) begin
      edge_n(1);
      if (e == 9) nif.btn_raw = 4'b0000;
      exp_data = (e >= 6) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (nif.btn_data !== exp_data || nif.pending !== (|exp_data)) begin
        tests_failed++;
        $display("FAIL sticky_hold edge %0d: got data=%b pend=%b required data=%b pend=%b",
                 e, nif.btn_data, nif.pending, exp_data, |exp_data);
      end
    end
    nif.rd_strobe = 1'b1;
    edge_n(1);
    nif.rd_strobe = 1'b0;
    tests_run++;
    if (nif.btn_data !== 4'b0000 || nif.pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_clear: got data=%b pend=%b required data=0000 pend=0",
               nif.btn_data, nif.pending);
    end
    cleanup();
  endtask

  task automatic test_set_clear();
    nif.btn_raw = 4'b0001;
    edge_n(7);
    tests_run++;
    if (nif.btn_data !== 4'b0001) begin
      tests_failed++;
      $display("FAIL set_clear_pre: got data=%b required 0001", nif.btn_data);
    end
    nif.btn_raw = 4'b1000;
    edge_n(6);
    // Rise on bit 3 is now visible; read in this same cycle.
    tests_run++;
    if (nif.btn_rise !== 4'b1000 || nif.btn_data !== 4'b0001) begin
      tests_failed++;
      $display("FAIL set_clear_rise: got rise=%b data=%b required rise=1000 data=0001",
               nif.btn_rise, nif.btn_data);
    end
    nif.rd_strobe = 1'b1;
    edge_n(1);
    nif.rd_strobe = 1'b0;
    tests_run++;
    if (nif.btn_data !== 4'b1000 || nif.pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_clear: got data=%b pend=%b required data=1000 pend=1",
               nif.btn_data, nif.pending);
    end
    cleanup();
  endtask
`endif

  task automatic test_reset_mid();
    logic [3:0] exp_level, exp_data;
    nif.btn_raw = 4'b0001;
    edge_n(4);  // count has reached 2 after edge 3
`ifndef INPUT_STICKY_EN
    nif.rd_strobe = 1'b1;
`endif
    reset = 1'b1;
    #1;
    tests_run++;
    if ({nif.btn_level, nif.btn_rise, nif.btn_data, nif.pending} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got lvl=%b rise=%b data=%b pend=%b required all 0",
               nif.btn_level, nif.btn_rise, nif.btn_data, nif.pending);
    end
    edge_n(2);
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      edge_n(1);
      exp_level = (e >= 5) ? 4'b0001 : 4'b0000;
`ifdef INPUT_STICKY_EN
      exp_data  = (e >= 6) ? 4'b0001 : 4'b0000;
`else
      exp_data  = exp_level;
`endif
      tests_run++;
      if (nif.btn_level !== exp_level || nif.btn_rise !== ((e == 5) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL reset_mid edge %0d: got lvl=%b rise=%b required lvl=%b rise=%b",
                 e, nif.btn_level, nif.btn_rise, exp_level, (e == 5) ? 4'b0001 : 4'b0000);
      end
      tests_run++;
      if (nif.btn_data !== exp_data || nif.pending !== (|exp_data)) begin
        tests_failed++;
        $display("FAIL reset_mid_data edge %0d: got data=%b pend=%b required data=%b pend=%b",
                 e, nif.btn_data, nif.pending, exp_data, |exp_data);
      end
    end
    cleanup();
  endtask

  initial begin
    nif.btn_raw   = 4'b0000;
    nif.tick      = 1'b1;
    nif.rd_strobe = 1'b0;
    reset         = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
`ifdef INPUT_STICKY_EN
    test_sticky_read();
    test_set_clear();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/nibble_input_conditioner.md
# nibble_input_conditioner

Four-channel pushbutton conditioner placed directly upstream of the nibbler processor's IN port. It synchronizes each raw button, debounces it, detects the press edge, and presents a clean nibble on `btn_data` for the processor's `pushbuttons` input. An optional press latch holds each press until the processor executes IN, so short presses are not missed between instructions.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 15: number of consecutive `tick`-qualified samples that must differ from the stable value before it changes. Legal range 1..65535. The counter is 16 bits wide.

Ports:
- `clk`  in  1  system clock; the processor clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  4  raw, asynchronous button levels; 1 = pressed.
- `tick`  in  1  debounce sample enable; tie to 1 to sample every `clk`.
- `rd_strobe`  in  1  IN-read acknowledge; connect to oeIN (control_signals[2]).
- `btn_level`  out  4  debounced level per channel.
- `btn_rise`  out  4  one-`clk` pulse on each debounced 0→1 transition.
- `btn_data`  out  4  nibble presented to the processor's `pushbuttons` input.
- `pending`  out  1  at least one bit of `btn_data` is set.

## Operation

- Synchronizer: 2 flip-flops per channel (`sync1`, then `sync2`), clocked every `clk` regardless of `tick`.
- Debounce, independent per channel: a `stable` register and a 16-bit `count`.
  - `sync2 == stable`: `count` is cleared to 0 on that edge, whether or not `tick` is high.
  - `sync2 != stable` and `tick = 1`:
    - If `count == DEBOUNCE_CYCLES-1`: `stable <= sync2` and `count <= 0`.
    - Otherwise: `count <= count+1`.
  - `sync2 != stable` and `tick = 0`: `count` holds.
  - A single agreeing sample restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` samples never reach `stable`.
- `btn_level = stable`.
- `btn_rise[i]` is registered. It is 1 for exactly the one cycle following the edge where `stable[i]` goes 0→1. No pulse is generated on release.
- Press latch, `press[3:0]`, present only with the macro:
  - On each edge: `press <= (press & ~{4{rd_strobe}}) | btn_rise`.
  - Clearing applies to all 4 bits at once.
  - If a rise and `rd_strobe` occur in the same cycle, the set wins for that bit.
- Reset: `sync1`, `sync2`, `stable`, `count`, `btn_rise`, and `press` all go to 0. Every output is therefore 0 during and after reset.
  - Reset mid-debounce discards partial counts.
  - A button held through reset is seen as a fresh press after release of reset, once it passes the full debounce.

## Timing

- Latency from raw to level, with `tick = 1`: a `btn_raw` change set up before edge E0 appears on `btn_level` after edge E0+`DEBOUNCE_CYCLES`+1.
- With gated `tick`: `DEBOUNCE_CYCLES` qualifying ticks are needed after `sync2` changes.
- `btn_rise` is asserted in the cycle after that same edge.
- `btn_data` and `pending` are combinational from registers; no extra latency.
- `rd_strobe` is sampled at the `clk` edge that ends the execute cycle of IN.
  - The processor reads `btn_data` during that cycle.
  - `btn_data` clears on that edge.
- `rd_strobe` held for multiple cycles simply keeps clearing the latch. Rise pulses during that window still set it.

## Configuration

- `INPUT_STICKY_EN` defined:
  - `press` latch is built.
  - `btn_data = press`.
  - `pending = |press`.
  - `rd_strobe` clears the latch.
- `INPUT_STICKY_EN` undefined:
  - No latch.
  - `btn_data = btn_level`.
  - `pending = |btn_level`.
  - `rd_strobe` is ignored.

## Test plan

Unless noted, `DEBOUNCE_CYCLES = 4` and `tick = 1`.

- Reset: with `btn_raw = 1111` and `reset` held for 3 cycles, all outputs are 0. After release, `btn_level = 1111` after edge 5, and `btn_rise = 1111` for exactly one cycle.
- Clean press: `btn_raw = 0001` before edge 0 → `btn_level = 0001` after edge 5 and `btn_rise = 0001` for one cycle. Releasing at edge 20 → `btn_level = 0000` after edge 25, with no rise pulse.
- Glitch rejection: bit 1 high for 3 cycles, then low → `btn_level[1]` stays 0 and `btn_rise` stays 0. Also run with `tick` asserted only every 3rd `clk`: a press needs 4 ticks after `sync2` changes.
- Sticky read (macro on):
  - Pulse bit 2 for 10 cycles, then release → `btn_data = 0100` and `pending = 1` stay set indefinitely.
  - Assert `rd_strobe` for one cycle → `btn_data = 0000` and `pending = 0` after that edge.
- Simultaneous set and clear (macro on): `press = 0001`, and a bit 3 rise coincides with `rd_strobe` → `btn_data = 1000` after the edge.
- Reset mid-debounce: assert `reset` when `count = 2` → all outputs are 0. After release, the same held press needs the full latency (edge +5) again. With the macro off, `btn_data` equals `btn_level` throughout and `rd_strobe` has no effect.
